// File: rtl/pll_drp_pkg.sv
// Shared types and DRP register map for the PLL reconfiguration master.
// Holds the FSM state encoding, bus widths and the default table addresses.
package pll_drp_pkg;

    localparam int DRP_AW = 7;
    localparam int DRP_DW = 16;
    localparam int DEFAULT_ENTRIES = 23;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST_ASSERT,
        S_RD_REQ,
        S_RD_GAP,
        S_RD_WAIT,
        S_WR_REQ,
        S_WR_GAP,
        S_WR_WAIT,
        S_NEXT,
        S_RST_RELEASE,
        S_LOCK_WAIT,
        S_FAIL
    } state_t;

    localparam logic [6:0] CLKOUT5_REG1  = 7'h06;
    localparam logic [6:0] CLKOUT5_REG2  = 7'h07;
    localparam logic [6:0] CLKOUT0_REG1  = 7'h08;
    localparam logic [6:0] CLKOUT0_REG2  = 7'h09;
    localparam logic [6:0] CLKOUT1_REG1  = 7'h0A;
    localparam logic [6:0] CLKOUT1_REG2  = 7'h0B;
    localparam logic [6:0] CLKOUT2_REG1  = 7'h0C;
    localparam logic [6:0] CLKOUT2_REG2  = 7'h0D;
    localparam logic [6:0] CLKOUT3_REG1  = 7'h0E;
    localparam logic [6:0] CLKOUT3_REG2  = 7'h0F;
    localparam logic [6:0] CLKOUT4_REG1  = 7'h10;
    localparam logic [6:0] CLKOUT4_REG2  = 7'h11;
    localparam logic [6:0] CLKOUT6_REG1  = 7'h12;
    localparam logic [6:0] CLKOUT6_REG2  = 7'h13;
    localparam logic [6:0] CLKFBOUT_REG1 = 7'h14;
    localparam logic [6:0] CLKFBOUT_REG2 = 7'h15;
    localparam logic [6:0] DIVCLK_REG    = 7'h16;
    localparam logic [6:0] LOCK_REG1     = 7'h18;
    localparam logic [6:0] LOCK_REG2     = 7'h19;
    localparam logic [6:0] LOCK_REG3     = 7'h1A;
    localparam logic [6:0] POWER_REG     = 7'h28;
    localparam logic [6:0] FILT_REG1     = 7'h4E;
    localparam logic [6:0] FILT_REG2     = 7'h4F;

    // Canonical ordering of a full 23-entry reconfiguration table.
    function automatic logic [6:0] default_addr(input int idx);
        case (idx)
            0:  return CLKOUT0_REG1;
            1:  return CLKOUT0_REG2;
            2:  return CLKOUT1_REG1;
            3:  return CLKOUT1_REG2;
            4:  return CLKOUT2_REG1;
            5:  return CLKOUT2_REG2;
            6:  return CLKOUT3_REG1;
            7:  return CLKOUT3_REG2;
            8:  return CLKOUT4_REG1;
            9:  return CLKOUT4_REG2;
            10: return CLKOUT5_REG1;
            11: return CLKOUT5_REG2;
            12: return CLKOUT6_REG1;
            13: return CLKOUT6_REG2;
            14: return CLKFBOUT_REG1;
            15: return CLKFBOUT_REG2;
            16: return DIVCLK_REG;
            17: return LOCK_REG1;
            18: return LOCK_REG2;
            19: return LOCK_REG3;
            20: return POWER_REG;
            21: return FILT_REG1;
            22: return FILT_REG2;
            default: return 7'h00;
        endcase
    endfunction

endpackage

// File: rtl/pll_drp_if.sv
// DRP bus between the reconfiguration master and the PLL primitive.
// master: drives DADDR/DEN/DWE/DI, receives DO/DRDY; slave is the mirror.
interface pll_drp_if;
    import pll_drp_pkg::*;

    logic [DRP_AW-1:0] DADDR;
    logic              DEN;
    logic              DWE;
    logic [DRP_DW-1:0] DI;
    logic [DRP_DW-1:0] DO;
    logic              DRDY;

    modport master (
        output DADDR, DEN, DWE, DI,
        input  DO, DRDY
    );

    modport slave (
        input  DADDR, DEN, DWE, DI,
        output DO, DRDY
    );

endinterface

// File: rtl/drp_timeout_cnt.sv
// Loadable saturating down-counter used for DRDY and LOCKED timeouts.
// Ports: DCLK, RST (async high), load/load_val, dec, zero (count == 0).
module drp_timeout_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             DCLK,
    input  logic             RST,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge DCLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pll_drp_master.sv
// Walks an external register table, read-modify-writing each PLL DRP register
// while holding the PLL in reset, then waits for lock.
// Ports: DCLK, RST, START, TBL_IDX/TBL_ADDR/TBL_MASK/TBL_DATA (table),
// drp (DRP master bus), LOCKED, PLL_RST, BUSY, DONE, ERR.
module pll_drp_master
    import pll_drp_pkg::*;
#(
    parameter int NUM_ENTRIES  = 23,
    parameter int DRDY_TIMEOUT = 255,
    parameter int LOCK_TIMEOUT = 4095
) (
    input  logic        DCLK,
    input  logic        RST,
    input  logic        START,
    output logic [4:0]  TBL_IDX,
    input  logic [6:0]  TBL_ADDR,
    input  logic [15:0] TBL_MASK,
    input  logic [15:0] TBL_DATA,
    pll_drp_if.master   drp,
    input  logic        LOCKED,
    output logic        PLL_RST,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);

    localparam int DW = $clog2(DRDY_TIMEOUT + 1);
    localparam int LW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [4:0]    LAST      = 5'(NUM_ENTRIES - 1);
    localparam logic [DW-1:0] DRDY_LOAD = DW'(DRDY_TIMEOUT);
    // Counting down to and including zero gives LOCK_TIMEOUT wait cycles.
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCK_TIMEOUT - 1);

    state_t      state;
    logic [6:0]  addr_q;
    logic [15:0] di_q;
    logic        den_q;
    logic        dwe_q;

    logic drdy_load;
    logic drdy_dec;
    logic drdy_zero;
    logic lock_load;
    logic lock_dec;
    logic lock_zero;

    assign drdy_load = (state == S_RD_REQ) || (state == S_WR_REQ);
    assign drdy_dec  = (state == S_RD_GAP) || (state == S_RD_WAIT) ||
                       (state == S_WR_GAP) || (state == S_WR_WAIT);
    assign lock_load = (state == S_RST_RELEASE);
    assign lock_dec  = (state == S_LOCK_WAIT);

    drp_timeout_cnt #(.WIDTH(DW)) u_drdy_cnt (
        .DCLK     (DCLK),
        .RST      (RST),
        .load     (drdy_load),
        .load_val (DRDY_LOAD),
        .dec      (drdy_dec),
        .zero     (drdy_zero)
    );

    drp_timeout_cnt #(.WIDTH(LW)) u_lock_cnt (
        .DCLK     (DCLK),
        .RST      (RST),
        .load     (lock_load),
        .load_val (LOCK_LOAD),
        .dec      (lock_dec),
        .zero     (lock_zero)
    );

    // TBL_IDX only settles in RD_REQ itself, so the address is taken straight
    // from the table during the read strobe and held from then on.
    assign drp.DADDR = (state == S_RD_REQ) ? TBL_ADDR : addr_q;
    assign drp.DEN   = den_q;
    assign drp.DWE   = dwe_q;
    assign drp.DI    = di_q;

    always_ff @(posedge DCLK or posedge RST) begin
        if (RST) begin
            state   <= S_IDLE;
            TBL_IDX <= '0;
            addr_q  <= '0;
            di_q    <= '0;
            den_q   <= 1'b0;
            dwe_q   <= 1'b0;
            PLL_RST <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            ERR     <= 1'b0;
        end else begin
            den_q <= 1'b0;
            dwe_q <= 1'b0;
            DONE  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (START) begin
                        ERR     <= 1'b0;
                        TBL_IDX <= '0;
                        BUSY    <= 1'b1;
                        PLL_RST <= 1'b1;
                        state   <= S_RST_ASSERT;
                    end
                end
                S_RST_ASSERT: begin
                    den_q <= 1'b1;
                    state <= S_RD_REQ;
                end
                S_RD_REQ: begin
                    addr_q <= TBL_ADDR;
                    state  <= S_RD_GAP;
                end
                S_RD_GAP: begin
                    state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    // DRDY wins over an expiring counter.
                    if (drp.DRDY) begin
                        di_q  <= (drp.DO & TBL_MASK) | TBL_DATA;
                        den_q <= 1'b1;
                        dwe_q <= 1'b1;
                        state <= S_WR_REQ;
                    end else if (drdy_zero) begin
                        state <= S_FAIL;
                    end
                end
                S_WR_REQ: begin
                    state <= S_WR_GAP;
                end
                S_WR_GAP: begin
                    state <= S_WR_WAIT;
                end
                S_WR_WAIT: begin
                    if (drp.DRDY) begin
                        state <= S_NEXT;
                    end else if (drdy_zero) begin
                        state <= S_FAIL;
                    end
                end
                S_NEXT: begin
                    if (TBL_IDX == LAST) begin
                        state <= S_RST_RELEASE;
                    end else begin
                        TBL_IDX <= TBL_IDX + 5'd1;
                        den_q   <= 1'b1;
                        state   <= S_RD_REQ;
                    end
                end
                S_RST_RELEASE: begin
                    PLL_RST <= 1'b0;
                    state   <= S_LOCK_WAIT;
                end
                S_LOCK_WAIT: begin
                    if (LOCKED) begin
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= S_IDLE;
                    end else if (lock_zero) begin
                        state <= S_FAIL;
                    end
                end
                S_FAIL: begin
                    ERR     <= 1'b1;
                    PLL_RST <= 1'b0;
                    BUSY    <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_drp_master.sv
// Testbench for pll_drp_master: random DRP responder, PLL lock model and
// reference expectations derived from the register table.
module tb_pll_drp_master;
    import pll_drp_pkg::*;

    localparam int N  = 23;
    localparam int DT = 255;
    localparam int LT = 4095;

    logic        DCLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        LOCKED = 1'b0;
    logic [4:0]  TBL_IDX;
    logic [6:0]  TBL_ADDR;
    logic [15:0] TBL_MASK;
    logic [15:0] TBL_DATA;
    logic        PLL_RST;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    always #5 DCLK = ~DCLK;

    pll_drp_if drp ();

    pll_drp_master #(
        .NUM_ENTRIES  (N),
        .DRDY_TIMEOUT (DT),
        .LOCK_TIMEOUT (LT)
    ) dut (
        .DCLK     (DCLK),
        .RST      (RST),
        .START    (START),
        .TBL_IDX  (TBL_IDX),
        .TBL_ADDR (TBL_ADDR),
        .TBL_MASK (TBL_MASK),
        .TBL_DATA (TBL_DATA),
        .drp      (drp),
        .LOCKED   (LOCKED),
        .PLL_RST  (PLL_RST),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .ERR      (ERR)
    );

    logic [6:0]  t_addr [32];
    logic [15:0] t_mask [32];
    logic [15:0] t_data [32];

    assign TBL_ADDR = t_addr[TBL_IDX];
    assign TBL_MASK = t_mask[TBL_IDX];
    assign TBL_DATA = t_data[TBL_IDX];

    typedef struct {
        logic        wr;
        logic [6:0]  a;
        logic [15:0] d;
        int          t;
    } acc_t;

    acc_t        log_q [$];
    logic [15:0] mem [128];
    logic [15:0] rv [128];

    // mode 0: DRDY pulse after random latency, 1: never, 2: held high
    int  mode = 0;
    int  lat_lo = 2;
    int  lat_hi = 2;
    bit  lock_ok = 1'b1;
    int  run_id = 0;
    int  seen_id = 0;
    int  cnt = 0;
    int  cyc = 0;
    int  den_cnt = 0;
    int  done_cnt = 0;
    int  bad = 0;
    int  lcnt = 0;
    logic prev_den = 1'b0;
    logic prev_done = 1'b0;
    logic [15:0] pend = '0;

    int checks = 0;
    int errors = 0;
    int lbase, dbase, obase;

    always @(negedge DCLK) begin
        logic rdy;
        cyc++;
        rdy = 1'b0;
        if (run_id != seen_id) begin
            seen_id = run_id;
            for (int a = 0; a < 128; a++) mem[a] = rv[a];
            cnt = 0;
        end
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                rdy = 1'b1;
                drp.DO = pend;
            end
        end
        if (drp.DWE && !drp.DEN) bad++;
        if (DONE) begin
            done_cnt++;
            if (prev_done) bad++;
        end
        if (drp.DEN) begin
            den_cnt++;
            if (prev_den || !PLL_RST) bad++;
            if (drp.DWE) begin
                log_q.push_back('{1'b1, drp.DADDR, drp.DI, cyc});
                mem[drp.DADDR] = drp.DI;
            end else begin
                pend = mem[drp.DADDR];
                log_q.push_back('{1'b0, drp.DADDR, pend, cyc});
            end
            if (mode == 2) drp.DO = pend;
            if (mode == 0) cnt = int'($urandom_range(lat_hi, lat_lo));
        end
        prev_den = drp.DEN;
        prev_done = DONE;
        drp.DRDY = (mode == 2) ? 1'b1 : rdy;
        if (PLL_RST || !lock_ok) begin
            lcnt = 0;
            LOCKED = 1'b0;
        end else if (lcnt < 10) begin
            lcnt++;
            LOCKED = (lcnt == 10);
        end
    end

    task automatic tick();
        @(negedge DCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_table();
        for (int i = 0; i < 32; i++) begin
            t_addr[i] = (i < N) ? default_addr(i) : 7'h00;
            t_mask[i] = 16'($urandom);
            t_data[i] = 16'($urandom) & ~t_mask[i];
        end
        t_mask[0] = 16'h1000;
        t_data[0] = 16'h0041;
    endtask

    task automatic start_run(input string tag, input int m, input int lo,
                             input int hi, input bit lk);
        mode = m;
        lat_lo = lo;
        lat_hi = hi;
        lock_ok = lk;
        run_id++;
        tick();
        lbase = log_q.size();
        dbase = den_cnt;
        obase = done_cnt;
        START = 1'b1;
        tick();
        START = 1'b0;
        chk({tag, "_busy_on"}, BUSY, 1);
        chk({tag, "_pllrst_on"}, PLL_RST, 1);
        chk({tag, "_err_clr"}, ERR, 0);
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (DONE) begin
                ok = 1'b1;
                break;
            end
            if (ERR) break;
        end
    endtask

    // Expected: per entry one read returning the reset value, then one
    // write of (reset & mask) | data to the same address.
    task automatic check_run(input string tag, input bit timed);
        int nbad;
        nbad = 0;
        chk({tag, "_den"}, den_cnt - dbase, 2 * N);
        chk({tag, "_len"}, log_q.size() - lbase, 2 * N);
        if (log_q.size() - lbase == 2 * N) begin
            for (int i = 0; i < N; i++) begin
                acc_t r, w;
                logic [15:0] e;
                r = log_q[lbase + 2 * i];
                w = log_q[lbase + 2 * i + 1];
                e = (rv[t_addr[i]] & t_mask[i]) | t_data[i];
                if (r.wr !== 1'b0 || r.a !== t_addr[i] || r.d !== rv[t_addr[i]]) nbad++;
                if (w.wr !== 1'b1 || w.a !== t_addr[i] || w.d !== e) nbad++;
                if (mem[t_addr[i]] !== e) nbad++;
            end
            chk({tag, "_seq"}, nbad, 0);
            if (timed)
                chk({tag, "_span"}, log_q[lbase + 2 * N - 2].t - log_q[lbase].t, 7 * (N - 1));
        end
    endtask

    initial begin
        bit ok;
        bit found;
        for (int a = 0; a < 128; a++) rv[a] = 16'($urandom);
        rv[8] = 16'hFFFF;
        rand_table();

        repeat (3) tick();
        chk("rst_idx", TBL_IDX, 0);
        chk("rst_daddr", drp.DADDR, 0);
        chk("rst_di", drp.DI, 0);
        chk("rst_den", drp.DEN, 0);
        chk("rst_dwe", drp.DWE, 0);
        chk("rst_pllrst", PLL_RST, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_err", ERR, 0);
        RST = 1'b0;
        repeat (2) tick();

        // Minimum-latency responder: 7 cycles per entry.
        start_run("min", 0, 2, 2, 1'b1);
        wait_done(1000, ok);
        chk("min_done", ok, 1);
        chk("min_busy_off", BUSY, 0);
        chk("min_err", ERR, 0);
        chk("min_entry0_di", log_q[lbase + 1].d, 16'h1041);
        check_run("min", 1'b1);

        // Random latency, START pulsed during entry 5 must be ignored.
        start_run("rnd", 0, 2, 7, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            tick();
            found = (TBL_IDX == 5'd5);
        end
        chk("rnd_reach5", found, 1);
        START = 1'b1;
        tick();
        START = 1'b0;
        wait_done(3000, ok);
        chk("rnd_done", ok, 1);
        chk("rnd_done_cnt", done_cnt - obase, 1);
        check_run("rnd", 1'b0);

        // DRDY stuck high: gap cycle still honoured.
        rand_table();
        start_run("hi", 2, 0, 0, 1'b1);
        wait_done(1000, ok);
        chk("hi_done", ok, 1);
        check_run("hi", 1'b1);

        // DRDY never comes.
        start_run("nordy", 1, 0, 0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = (den_cnt - dbase == 1);
        end
        chk("nordy_den", found, 1);
        repeat (DT) tick();
        chk("nordy_err_early", ERR, 0);
        repeat (4) tick();
        chk("nordy_err", ERR, 1);
        chk("nordy_busy", BUSY, 0);
        chk("nordy_pllrst", PLL_RST, 0);
        chk("nordy_nodone", done_cnt - obase, 0);
        chk("nordy_den_cnt", den_cnt - dbase, 1);

        // LOCKED never rises.
        start_run("nolock", 0, 2, 4, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            tick();
            found = !PLL_RST;
        end
        chk("nolock_release", found, 1);
        repeat (LT - 2) tick();
        chk("nolock_err_early", ERR, 0);
        repeat (4) tick();
        chk("nolock_err", ERR, 1);
        chk("nolock_busy", BUSY, 0);
        chk("nolock_nodone", done_cnt - obase, 0);
        check_run("nolock", 1'b0);

        // Asynchronous reset while the entry-3 write strobe is up.
        start_run("arst", 0, 2, 3, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            found = (den_cnt - dbase == 8);
        end
        chk("arst_reach", found, 1);
        chk("arst_dwe_before", drp.DWE, 1);
        RST = 1'b1;
        #1;
        chk("arst_den", drp.DEN, 0);
        chk("arst_dwe", drp.DWE, 0);
        chk("arst_pllrst", PLL_RST, 0);
        chk("arst_busy", BUSY, 0);
        chk("arst_idx", TBL_IDX, 0);
        chk("arst_daddr", drp.DADDR, 0);
        chk("arst_di", drp.DI, 0);
        repeat (3) tick();
        RST = 1'b0;
        repeat (30) tick();
        chk("arst_no_den", den_cnt - dbase, 8);
        chk("arst_pllrst_after", PLL_RST, 0);
        chk("arst_nodone", done_cnt - obase, 0);

        chk("protocol", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
